// File: rtl/display_pkg.sv
// display_pkg: sprite geometry, character indices, colours and 5x5 bitmaps shared by the display controllers.
// CHAR_TRANSPARENT_EN: when defined, bitmap-0 sprite pixels are not plotted.
package display_pkg;

    localparam int SPRITE_SIZE = 5;
    localparam int NUM_CHARS   = 5;

    localparam logic [2:0] CHAR_PACMAN = 3'd0;
    localparam logic [2:0] CHAR_GHOST1 = 3'd1;
    localparam logic [2:0] CHAR_GHOST2 = 3'd2;
    localparam logic [2:0] CHAR_GHOST3 = 3'd3;
    localparam logic [2:0] CHAR_GHOST4 = 3'd4;

    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_PACMAN = 3'b110;
    localparam logic [2:0] COLOR_GHOST1 = 3'b100;
    localparam logic [2:0] COLOR_GHOST2 = 3'b101;
    localparam logic [2:0] COLOR_GHOST3 = 3'b011;
    localparam logic [2:0] COLOR_GHOST4 = 3'b010;

    // Row dy0 in the top bits, dx0 leftmost: pixel (dx,dy) lives at bit 24 - (dy*5 + dx).
    localparam logic [24:0] BMP_PACMAN_RIGHT = 25'b01110_11100_11000_11100_01110;
    localparam logic [24:0] BMP_PACMAN_LEFT  = 25'b01110_00111_00011_00111_01110;
    localparam logic [24:0] BMP_GHOST        = 25'b01110_11111_10101_11111_10101;

`ifdef CHAR_TRANSPARENT_EN
    localparam bit CHAR_TRANSPARENT = 1'b1;
`else
    localparam bit CHAR_TRANSPARENT = 1'b0;
`endif

endpackage

// File: rtl/char_sprite_rom.sv
// char_sprite_rom: combinational lookup of one sprite pixel -> {opaque, colour}.
module char_sprite_rom
    import display_pkg::*;
(
    input  logic [2:0] char_idx,
    input  logic       orientation,
    input  logic [2:0] dx,
    input  logic [2:0] dy,
    output logic       opaque,
    output logic [2:0] colour
);

    logic [24:0] bitmap;
    logic [4:0]  bit_idx;
    logic [2:0]  char_colour;

    always_comb begin
        bitmap      = char_idx == CHAR_PACMAN ? (orientation ? BMP_PACMAN_LEFT : BMP_PACMAN_RIGHT) : BMP_GHOST;
        bit_idx     = 5'd24 - (5'(dy) * 5'(SPRITE_SIZE) + 5'(dx));
        char_colour = char_idx == CHAR_PACMAN ? COLOR_PACMAN :
                      char_idx == CHAR_GHOST1 ? COLOR_GHOST1 :
                      char_idx == CHAR_GHOST2 ? COLOR_GHOST2 :
                      char_idx == CHAR_GHOST3 ? COLOR_GHOST3 : COLOR_GHOST4;
        opaque      = bitmap[bit_idx];
        colour      = opaque ? char_colour : COLOR_BLACK;
    end

endmodule

// File: rtl/character_display_controller.sv
// character_display_controller: free-running scan that draws the five 5x5 character sprites, one pixel per clock.
module character_display_controller
    import display_pkg::*;
(
    input  logic       clock_50,
    input  logic       reset,
    input  logic       pacman_orientation,
    output logic [2:0] character_type,
    input  logic [7:0] char_x,
    input  logic [7:0] char_y,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_color
);

    localparam logic [2:0] LAST_D    = 3'(SPRITE_SIZE - 1);
    localparam logic [2:0] LAST_CHAR = 3'(NUM_CHARS - 1);

    logic [2:0] char_idx, dx, dy;
    logic       opaque;
    logic [2:0] colour;

    assign character_type = char_idx;

    char_sprite_rom u_rom (
        .char_idx    (char_idx),
        .orientation (pacman_orientation),
        .dx          (dx),
        .dy          (dy),
        .opaque      (opaque),
        .colour      (colour)
    );

    // dx/dy counters stand in for pix_idx % 5 and pix_idx / 5.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            char_idx  <= CHAR_PACMAN;
            dx        <= 3'd0;
            dy        <= 3'd0;
            vga_plot  <= 1'b0;
            vga_x     <= 8'd0;
            vga_y     <= 8'd0;
            vga_color <= COLOR_BLACK;
        end else begin
            vga_x     <= char_x + {5'd0, dx};
            vga_y     <= char_y + {5'd0, dy};
            vga_color <= colour;
            vga_plot  <= opaque || !CHAR_TRANSPARENT;
            dx        <= dx == LAST_D ? 3'd0 : dx + 3'd1;
            if (dx == LAST_D) begin
                dy <= dy == LAST_D ? 3'd0 : dy + 3'd1;
                if (dy == LAST_D)
                    char_idx <= char_idx == LAST_CHAR ? CHAR_PACMAN : char_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_character_display_controller.sv
// tb_character_display_controller: scan model plus directed literal checks for character_display_controller.
module tb_character_display_controller;

    logic       clock_50 = 1'b0;
    logic       reset = 1'b1;
    logic       pacman_orientation = 1'b0;
    logic [2:0] character_type;
    logic [7:0] char_x, char_y;
    logic       vga_plot;
    logic [7:0] vga_x, vga_y;
    logic [2:0] vga_color;

    logic [7:0] pos_x [5] = '{8'd10, 8'd254, 8'd30, 8'd100, 8'd200};
    logic [7:0] pos_y [5] = '{8'd20, 8'd255, 8'd40, 8'd50, 8'd100};

    int compared = 0;
    int mismatched = 0;

    assign char_x = pos_x[character_type];
    assign char_y = pos_y[character_type];

    character_display_controller dut (
        .clock_50           (clock_50),
        .reset              (reset),
        .pacman_orientation (pacman_orientation),
        .character_type     (character_type),
        .char_x             (char_x),
        .char_y             (char_y),
        .vga_plot           (vga_plot),
        .vga_x              (vga_x),
        .vga_y              (vga_y),
        .vga_color          (vga_color)
    );

    always #5 clock_50 = ~clock_50;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    string pac_r [5] = '{"01110", "11100", "11000", "11100", "01110"};
    string pac_l [5] = '{"01110", "00111", "00011", "00111", "01110"};
    string ghost [5] = '{"01110", "11111", "10101", "11111", "10101"};
    int    col   [5] = '{6, 4, 5, 3, 2};

    function automatic bit lit(input int c, input bit o, input int dx, input int dy);
        string s;
        s = c == 0 ? (o ? pac_l[dy] : pac_r[dy]) : ghost[dy];
        return s[dx] == "1";
    endfunction

    // Model: scan position n over 0..124 of the full pass.
    int n = 0;
    int mp = 0, mx = 0, my = 0, mc = 0;

    always @(posedge clock_50) begin
        if (reset) begin
            mp = 0; mx = 0; my = 0; mc = 0; n = 0;
        end else begin
            int c, p;
            bit on;
            c  = n / 25;
            p  = n % 25;
            on = lit(c, pacman_orientation, p % 5, p / 5);
            mx = (int'(pos_x[c]) + p % 5) % 256;
            my = (int'(pos_y[c]) + p / 5) % 256;
            mc = on ? col[c] : 0;
`ifdef CHAR_TRANSPARENT_EN
            mp = on ? 1 : 0;
`else
            mp = 1;
`endif
            n = (n + 1) % 125;
        end
    end

    always @(negedge clock_50) begin
        chk("model_plot", int'(vga_plot), mp);
        chk("model_x", int'(vga_x), mx);
        chk("model_y", int'(vga_y), my);
        chk("model_color", int'(vga_color), mc);
        chk("model_type", int'(character_type), n / 25);
    end

    int pac_row0 [5] = '{0, 6, 6, 6, 0};
    int pac_row1l [5] = '{0, 0, 6, 6, 6};
    int g1_x [5] = '{254, 255, 0, 1, 2};

    initial begin
        repeat (3) @(negedge clock_50);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        chk("rst_y", int'(vga_y), 0);
        chk("rst_color", int'(vga_color), 0);
        chk("rst_type", int'(character_type), 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_50);
            chk("pac_x", int'(vga_x), 10 + i);
            chk("pac_y", int'(vga_y), 20);
            chk("pac_color", int'(vga_color), pac_row0[i]);
`ifdef CHAR_TRANSPARENT_EN
            chk("pac_plot", int'(vga_plot), pac_row0[i] != 0 ? 1 : 0);
`else
            chk("pac_plot", int'(vga_plot), 1);
`endif
        end
        repeat (19) @(negedge clock_50);
        chk("type_before_25", int'(character_type), 0);
        @(negedge clock_50);
        chk("type_at_25", int'(character_type), 1);
        pacman_orientation = 1'b1;
        repeat (105) @(negedge clock_50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_50);
            chk("pacl_x", int'(vga_x), 10 + i);
            chk("pacl_y", int'(vga_y), 21);
            chk("pacl_color", int'(vga_color), pac_row1l[i]);
        end
        repeat (65) @(negedge clock_50);
        for (int p = 0; p < 25; p++) begin
            @(negedge clock_50);
            chk("g3_x", int'(vga_x), 100 + p % 5);
            chk("g3_y", int'(vga_y), 50 + p / 5);
            if (p == 10) chk("g3_dx0dy2", int'(vga_color), 3);
            if (p == 11) chk("g3_dx1dy2", int'(vga_color), 0);
        end
        repeat (50) @(negedge clock_50);
        for (int p = 0; p < 25; p++) begin
            @(negedge clock_50);
            if (p < 5) chk("g1_x", int'(vga_x), g1_x[p]);
            if (p == 0) chk("g1_y0", int'(vga_y), 255);
            if (p == 5) chk("g1_y1", int'(vga_y), 0);
        end
        repeat (12) @(negedge clock_50);
        chk("g2_type", int'(character_type), 2);
        reset = 1'b1;
        @(negedge clock_50);
        chk("mid_rst_plot", int'(vga_plot), 0);
        chk("mid_rst_x", int'(vga_x), 0);
        chk("mid_rst_color", int'(vga_color), 0);
        chk("mid_rst_type", int'(character_type), 0);
        reset = 1'b0;
        @(negedge clock_50);
        chk("restart_x", int'(vga_x), 10);
        chk("restart_y", int'(vga_y), 20);
        chk("restart_color", int'(vga_color), 0);
        chk("restart_type", int'(character_type), 0);
        repeat (130) @(negedge clock_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
